// File: rtl/base_amem_rmw_upd.sv
// Read-modify-write updater for an SRAM of counters: mem[a] += delta, with
// one-cycle history forwarding and a small result FIFO on a valid/ready output.
module base_amem_rmw_upd #(
  parameter int awidth = 1,
  parameter int dwidth = 1,
  parameter int odepth = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_v,
  output logic              i_r,
  input  logic [awidth-1:0] i_a,
  input  logic [dwidth-1:0] i_d,
  output logic              rd_v,
  output logic [awidth-1:0] rd_a,
  input  logic [dwidth-1:0] rd_d,
  output logic              wr_v,
  output logic [awidth-1:0] wr_a,
  output logic [dwidth-1:0] wr_d,
  output logic              o_v,
  input  logic              o_r,
  output logic [awidth-1:0] o_a,
  output logic [dwidth-1:0] o_d
);

  localparam int PW = (odepth > 1) ? $clog2(odepth) : 1;
  localparam int CW = $clog2(odepth + 1);

  typedef struct packed {
    logic [awidth-1:0] a;
    logic [dwidth-1:0] d;
  } ent_t;

  logic             s1_v, hist_v;
  ent_t             s1, hist;
  ent_t             fifo [odepth];
  logic [PW-1:0]    rptr, wptr;
  logic [CW-1:0]    cnt;
  logic [CW:0]      need;
  logic [dwidth-1:0] base, sum;
  logic             acc, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(odepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reserve a slot for every op in flight so the FIFO can never overflow.
  assign need = {1'b0, cnt} + {{CW{1'b0}}, s1_v};
  assign i_r  = !reset && (need < (CW+1)'(odepth));
  assign acc  = i_v && i_r;

  assign rd_v = acc;
  assign rd_a = i_a;

  // Last cycle's write is not yet readable from SRAM (read returns old data).
  assign base = (hist_v && hist.a == s1.a) ? hist.d : rd_d;
  assign sum  = base + s1.d;

  assign wr_v = s1_v;
  assign wr_a = s1.a;
  assign wr_d = sum;

  assign push = s1_v;
  assign o_v  = (cnt != '0);
  assign pop  = o_v && o_r;
  assign o_a  = fifo[rptr].a;
  assign o_d  = fifo[rptr].d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v   <= 1'b0;
      s1     <= '0;
      hist_v <= 1'b0;
      hist   <= '0;
      rptr   <= '0;
      wptr   <= '0;
      cnt    <= '0;
    end else begin
      s1_v   <= acc;
      s1     <= '{a: i_a, d: i_d};
      hist_v <= s1_v;
      hist   <= '{a: s1.a, d: sum};
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= '{a: s1.a, d: sum};
  end

endmodule

// File: tb/tb_base_amem_rmw_upd.sv
// Randomized scoreboard bench for base_amem_rmw_upd with a behavioural SRAM
// and an array-based counter model updated at accept time.
module tb_base_amem_rmw_upd;
  localparam int AW = 3, DW = 8, OD = 3, N = 1 << AW;

  logic          clk = 1'b0, reset = 1'b1, i_v = 1'b0, o_r = 1'b0;
  logic [AW-1:0] i_a = '0;
  logic [DW-1:0] i_d = '0;
  logic          i_r, rd_v, wr_v, o_v;
  logic [AW-1:0] rd_a, wr_a, o_a;
  logic [DW-1:0] rd_d, wr_d, o_d;

  always #5 clk = ~clk;

  base_amem_rmw_upd #(.awidth(AW), .dwidth(DW), .odepth(OD)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_a(i_a), .i_d(i_d),
    .rd_v(rd_v), .rd_a(rd_a), .rd_d(rd_d), .wr_v(wr_v), .wr_a(wr_a), .wr_d(wr_d),
    .o_v(o_v), .o_r(o_r), .o_a(o_a), .o_d(o_d)
  );

  // SRAM: one-cycle read latency, same-cycle read of a written address sees old data.
  logic [DW-1:0] sram [N];
  logic [DW-1:0] seed [N];
  logic          load = 1'b1;
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < N; k++) sram[k] <= seed[k];
    end else begin
      if (rd_v) rd_d <= sram[rd_a];
      if (wr_v) sram[wr_a] <= wr_d;
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  op_t           out_q[$], wr_q[$];
  logic [DW-1:0] ref_mem [N];
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, describes what the next rising edge will do.
  logic          hold = 1'b0, acc_prev = 1'b0;
  logic [AW-1:0] ha;
  logic [DW-1:0] hd;
  always @(negedge clk) begin
    if (reset) begin
      out_q.delete();
      wr_q.delete();
      for (int k = 0; k < N; k++) ref_mem[k] = sram[k];
      hold     = 1'b0;
      acc_prev = 1'b0;
    end else begin
      op_t e;
      chk("i_r", i_r, out_q.size() < OD);
      chk("rd_v", rd_v, i_v && i_r);
      if (rd_v) chk("rd_a", rd_a, i_a);
      if (hold) begin
        chk("hold_v", o_v, 1);
        chk("hold_a", o_a, ha);
        chk("hold_d", o_d, hd);
      end
      hold = o_v && !o_r;
      ha = o_a;
      hd = o_d;
      chk("wr_latency", wr_v, acc_prev);
      if (wr_v) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_a", wr_a, e.a);
          chk("wr_d", wr_d, e.d);
        end
      end
      if (o_v && o_r) begin
        if (out_q.size() == 0) chk("o_unexpected", 1, 0);
        else begin
          e = out_q.pop_front();
          chk("o_a", o_a, e.a);
          chk("o_d", o_d, e.d);
        end
      end
      acc_prev = i_v && i_r;
      if (i_v && i_r) begin
        ref_mem[i_a] = ref_mem[i_a] + i_d;
        e.a = i_a;
        e.d = ref_mem[i_a];
        wr_q.push_back(e);
        out_q.push_back(e);
      end
    end
  end

  task automatic drive_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if ((c / 40) % 3 == 2) o_r = ($urandom_range(0, 7) == 0);
      else                   o_r = ($urandom_range(0, 3) != 0);
      i_v = ($urandom_range(0, 3) != 0);
      i_a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 1)) : AW'($urandom_range(0, N - 1));
      i_d = DW'($urandom);
    end
  endtask

  task automatic drain();
    int c;
    @(posedge clk); #1;
    i_v = 1'b0;
    o_r = 1'b1;
    c = 0;
    while (out_q.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_timeout", out_q.size(), 0);
  endtask

  task automatic op(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    i_v = 1'b1;
    i_a = a;
    i_d = d;
  endtask

  initial begin
    for (int k = 0; k < N; k++) seed[k] = DW'($urandom);
    seed[5] = 8'd10;
    seed[2] = 8'hFF;
    seed[7] = 8'd0;
    i_v = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_v", o_v, 0);
    chk("rst_rd_v", rd_v, 0);
    chk("rst_wr_v", wr_v, 0);
    chk("rst_i_r", i_r, 0);
    load = 1'b0;
    i_v = 1'b0;
    reset = 1'b0;
    o_r = 1'b1;

    // Directed: plain update, wrap, three back-to-back hits on one counter.
    op(5, 8'd3);
    op(2, 8'h02);
    op(7, 8'd1);
    op(7, 8'd1);
    op(7, 8'd1);
    drain();

    drive_random(1500);
    drain();

    // Fill with o_r low: ends with one op in s1 and two buffered, then reset.
    @(posedge clk); #1;
    o_r = 1'b0;
    i_v = 1'b1;
    i_a = 3'd1;
    i_d = 8'd1;
    repeat (3) @(posedge clk);
    #2;
    chk("fill_i_r", i_r, 0);
    chk("fill_o_v", o_v, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_o_v", o_v, 0);
    chk("mid_rst_wr_v", wr_v, 0);
    chk("mid_rst_i_r", i_r, 0);
    chk("mid_rst_rd_v", rd_v, 0);
    repeat (2) @(posedge clk);
    #1;
    i_v = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_i_r", i_r, 1);
    chk("post_rst_o_v", o_v, 0);

    drive_random(400);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
